// File: rtl/clock24_pkg.sv
// rtl/clock24_pkg.sv - BCD digit type, digit limits and disp_time field positions for clock_24hr
// time_valid() screens load_time when CLOCK24_LOAD_EN is defined.
package clock24_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX         = 4'd5;
  localparam bcd_t MIN_TENS_MAX         = 4'd5;
  localparam bcd_t UNITS_MAX            = 4'd9;
  localparam bcd_t HOUR_TENS_MAX        = 4'd2;
  localparam bcd_t HOUR_UNITS_MAX_AT_20 = 4'd3;

  localparam int DIGIT_W    = 4;
  localparam int SEC_U_LSB  = 0;
  localparam int SEC_T_LSB  = 4;
  localparam int MIN_U_LSB  = 8;
  localparam int MIN_T_LSB  = 12;
  localparam int HOUR_U_LSB = 16;
  localparam int HOUR_T_LSB = 20;

  function automatic logic time_valid(input logic [23:0] t);
    bcd_t ht, hu;
    ht = t[HOUR_T_LSB +: DIGIT_W];
    hu = t[HOUR_U_LSB +: DIGIT_W];
    return (t[SEC_U_LSB +: DIGIT_W] <= UNITS_MAX) &&
           (t[SEC_T_LSB +: DIGIT_W] <= SEC_TENS_MAX) &&
           (t[MIN_U_LSB +: DIGIT_W] <= UNITS_MAX) &&
           (t[MIN_T_LSB +: DIGIT_W] <= MIN_TENS_MAX) &&
           (ht <= HOUR_TENS_MAX) &&
           (hu <= ((ht == HOUR_TENS_MAX) ? HOUR_UNITS_MAX_AT_20 : UNITS_MAX));
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one BCD digit with runtime limit, wrap-to-zero and same-cycle carry out
module bcd_digit_counter
  import clock24_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic load,
  input  bcd_t load_value,
  input  bcd_t max_value,
  output bcd_t digit,
  output logic carry
);

  // Combinational carry so a full ripple resolves within one edge.
  assign carry = enable && (digit >= max_value);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_value;
    end else if (clear) begin
      digit <= '0;
    end else if (enable) begin
      digit <= (digit >= max_value) ? bcd_t'(0) : bcd_t'(digit + 4'd1);
    end
  end

endmodule

// File: rtl/clock_24hr.sv
// rtl/clock_24hr.sv - 24-hour BCD real-time clock with 1 Hz prescaler from kh_clk
// Optional load port pair enabled by CLOCK24_LOAD_EN.
module clock_24hr
  import clock24_pkg::*;
#(
  parameter int CLK_DIV = 1000
) (
  input  logic        kh_clk,
  input  logic        reset,
`ifdef CLOCK24_LOAD_EN
  input  logic        load,
  input  logic [23:0] load_time,
`endif
  output logic [23:0] disp_time
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] prescaler;
  logic          sec_tick;
  logic          do_load;
  logic [23:0]   load_value;
  logic [5:0]    enable;
  logic [5:0]    carry;
  logic [5:0]    clear;
  bcd_t          digit     [6];
  bcd_t          max_value [6];

`ifdef CLOCK24_LOAD_EN
  assign do_load    = load && time_valid(load_time);
  assign load_value = load_time;
`else
  assign do_load    = 1'b0;
  assign load_value = '0;
`endif

  assign sec_tick = (prescaler == PW'(CLK_DIV - 1));

  always_ff @(posedge kh_clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
    end else if (do_load || sec_tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Digit 0 is second units, digit 5 is hour tens.
  assign enable = {carry[4:0], sec_tick};

  assign max_value[0] = UNITS_MAX;
  assign max_value[1] = SEC_TENS_MAX;
  assign max_value[2] = UNITS_MAX;
  assign max_value[3] = MIN_TENS_MAX;
  assign max_value[4] = (digit[5] == HOUR_TENS_MAX) ? HOUR_UNITS_MAX_AT_20 : UNITS_MAX;
  assign max_value[5] = HOUR_TENS_MAX;

  // Hour-tens carry only fires at 23:59:59; force the hour pair to 00 explicitly.
  assign clear = {carry[5], carry[5], 4'b0000};

  for (genvar i = 0; i < 6; i++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk        (kh_clk),
      .rst_n      (reset),
      .enable     (enable[i]),
      .clear      (clear[i]),
      .load       (do_load),
      .load_value (load_value[i*DIGIT_W +: DIGIT_W]),
      .max_value  (max_value[i]),
      .digit      (digit[i]),
      .carry      (carry[i])
    );
  end

  assign disp_time[SEC_U_LSB  +: DIGIT_W] = digit[0];
  assign disp_time[SEC_T_LSB  +: DIGIT_W] = digit[1];
  assign disp_time[MIN_U_LSB  +: DIGIT_W] = digit[2];
  assign disp_time[MIN_T_LSB  +: DIGIT_W] = digit[3];
  assign disp_time[HOUR_U_LSB +: DIGIT_W] = digit[4];
  assign disp_time[HOUR_T_LSB +: DIGIT_W] = digit[5];

endmodule

// File: tb/tb_clock_24hr.sv
// tb/tb_clock_24hr.sv - randomized self-checking bench for clock_24hr against a seconds-count model
// Load tests compiled in when CLOCK24_LOAD_EN is defined.
module tb_clock_24hr;

  logic        kh_clk = 1'b0;
  logic        rst4 = 1'b0;
  logic        rst1 = 1'b0;
  logic        load4 = 1'b0;
  logic [23:0] load_time4 = 24'h0;
  logic [23:0] disp4;
  logic [23:0] disp1;
  int          n_checks = 0;
  int          n_fail = 0;
  int          base4 = 0;
  int          e4 = 0;
  int          e1 = 0;

  always #5 kh_clk = ~kh_clk;

  clock_24hr #(.CLK_DIV(4)) dut4 (
    .kh_clk    (kh_clk),
    .reset     (rst4),
`ifdef CLOCK24_LOAD_EN
    .load      (load4),
    .load_time (load_time4),
`endif
    .disp_time (disp4)
  );

  clock_24hr #(.CLK_DIV(1)) dut1 (
    .kh_clk    (kh_clk),
    .reset     (rst1),
`ifdef CLOCK24_LOAD_EN
    .load      (1'b0),
    .load_time (24'h0),
`endif
    .disp_time (disp1)
  );

  function automatic logic [23:0] sec2bcd(input int s);
    int t, h, m, x;
    t = s % 86400;
    h = t / 3600;
    m = (t / 60) % 60;
    x = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int bcd2sec(input logic [23:0] t);
    return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
           (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
           int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic logic legal_time(input logic [23:0] t);
    return (t[3:0] <= 9) && (t[7:4] <= 5) && (t[11:8] <= 9) && (t[15:12] <= 5) &&
           (t[19:16] <= 9) && (t[23:20] <= 2) &&
           (int'(t[23:20]) * 10 + int'(t[19:16]) <= 23);
  endfunction

  // Reference: elapsed edges since the last reset release or accepted load, divided into seconds.
  always @(posedge kh_clk or negedge rst4) begin
    if (!rst4) begin
      base4 = 0;
      e4 = 0;
    end else if (load4 && legal_time(load_time4)) begin
      base4 = bcd2sec(load_time4);
      e4 = 0;
    end else begin
      e4++;
    end
  end

  always @(posedge kh_clk or negedge rst1) begin
    if (!rst1) e1 = 0;
    else e1++;
  end

  function automatic logic [23:0] exp4();
    return sec2bcd(base4 + e4 / 4);
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step4(input string tag);
    @(negedge kh_clk);
    check(tag, disp4, exp4());
    check("digits_legal4", 24'(legal_time(disp4)), 24'h1);
  endtask

  task automatic mid_reset4();
    @(posedge kh_clk);
    #($urandom_range(1, 8));
    rst4 = 1'b0;
    #1;
    check("async_reset", disp4, 24'h000000);
    repeat ($urandom_range(1, 3)) @(negedge kh_clk);
    rst4 = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fork
      begin : div4_branch
        int guard;
        repeat (3) begin
          @(negedge kh_clk);
          check("reset_hold", disp4, 24'h000000);
        end
        rst4 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
          @(negedge kh_clk);
          check("release_edge", disp4, (k >= 8) ? 24'h000002 : (k >= 4) ? 24'h000001 : 24'h000000);
        end
        guard = 0;
        while (e4 / 4 < 37 && guard < 400) begin
          step4("run_to_37");
          guard++;
        end
        check("at_37", disp4, 24'h000037);
        mid_reset4();
        for (int k = 1; k <= 4; k++) begin
          @(negedge kh_clk);
          check("rerelease_edge", disp4, (k == 4) ? 24'h000001 : 24'h000000);
        end
        for (int it = 0; it < 20; it++) begin
          repeat ($urandom_range(1, 150)) step4("random_run");
          if ($urandom_range(0, 2) == 0) mid_reset4();
        end
`ifdef CLOCK24_LOAD_EN
        @(negedge kh_clk);
        load4 = 1'b1;
        load_time4 = 24'h235958;
        @(negedge kh_clk);
        load4 = 1'b0;
        check("load_value", disp4, 24'h235958);
        repeat (8) step4("after_load");
        check("load_wrap", disp4, 24'h000000);
        load4 = 1'b1;
        load_time4 = 24'h245900;
        step4("invalid_load");
        load4 = 1'b0;
        check("invalid_ignored", 24'(disp4 == 24'h245900), 24'h0);
        repeat (20) step4("after_invalid");
        for (int it = 0; it < 10; it++) begin
          load4 = 1'b1;
          load_time4 = $urandom();
          if (it % 2 == 0) load_time4 = sec2bcd($urandom_range(0, 86399));
          step4("random_load");
          load4 = 1'b0;
          repeat ($urandom_range(1, 20)) step4("random_load_run");
        end
`endif
      end
      begin : div1_branch
        repeat (2) @(negedge kh_clk);
        check("reset_hold1", disp1, 24'h000000);
        rst1 = 1'b1;
        for (int k = 1; k <= 86401; k++) begin
          @(negedge kh_clk);
          check("model1", disp1, sec2bcd(e1));
          case (k)
            59:    check("sec_59", disp1, 24'h000059);
            60:    check("min_carry", disp1, 24'h000100);
            3600:  check("hour_carry", disp1, 24'h010000);
            36000: check("ten_hours", disp1, 24'h100000);
            86399: check("day_end", disp1, 24'h235959);
            86400: check("day_wrap", disp1, 24'h000000);
            default: ;
          endcase
        end
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
